// File: rtl/vga_pkg.sv
// Shared constants for the VGA tile renderer: board geometry, palette,
// grid colour, swap FSM states and the pixel-to-tile mapping helper.
package vga_pkg;

  localparam int VGA_TILE_SHIFT = 5;
  localparam int VGA_COLS       = 20;
  localparam int VGA_ROWS       = 15;
  localparam int VGA_IDX_W      = 4;
  localparam int VGA_FC_W       = 16;

  localparam logic [23:0] GRID_COLOR = 24'h404040;

  // 16-entry EGA-style palette, indexed by the colour index read from RAM.
  localparam logic [23:0] PALETTE [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } swap_state_t;

  // Pixels past the board's right/bottom edge fold onto the last column/row.
  function automatic logic [8:0] tile_index(
    input logic [9:0]  x,
    input logic [9:0]  y,
    input int unsigned shift,
    input int unsigned cols,
    input int unsigned rows
  );
    int unsigned col;
    int unsigned row;
    col = 32'(x) >> shift;
    row = 32'(y) >> shift;
    if (col > cols - 1) col = cols - 1;
    if (row > rows - 1) row = rows - 1;
    return 9'(row * cols + col);
  endfunction

endpackage

// File: rtl/vga_tile_renderer_if.sv
// Frame-buffer read port and bank-swap handshake between the renderer
// (master) and the RAM / game logic (slave).
interface vga_tile_renderer_if #(
  parameter int IDX_W = 4,
  parameter int FC_W  = 16
);
  logic [9:0]       fb_addr;
  logic [IDX_W-1:0] fb_data;
  logic             swap_req;
  logic             swap_ack;
  logic             bank;
  logic [FC_W-1:0]  frame_count;

  modport master (
    output fb_addr,
    input  fb_data,
    input  swap_req,
    output swap_ack,
    output bank,
    output frame_count
  );

  modport slave (
    input  fb_addr,
    output fb_data,
    output swap_req,
    input  swap_ack,
    input  bank,
    input  frame_count
  );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth register chain with asynchronous reset to a configurable value,
// used to keep timing/control bits aligned with the RAM read path.
module vga_delay_line #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH:0][WIDTH-1:0] tap;

  assign tap[0] = d_i;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] stage_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage_q <= RST_VAL;
        end else begin
          stage_q <= tap[gi];
        end
      end

      assign tap[gi+1] = stage_q;
    end
  endgenerate

  assign q_o = tap[DEPTH];

endmodule

// File: rtl/vga_tile_renderer.sv
// Tile-map renderer: 3-stage pixel pipeline with double-buffered board swap.
// Optional grid overlay enabled by defining TILE_GRID_LINES_EN.
module vga_tile_renderer
  import vga_pkg::*;
#(
  parameter int TILE_SHIFT = VGA_TILE_SHIFT,
  parameter int COLS       = VGA_COLS,
  parameter int ROWS       = VGA_ROWS,
  parameter int IDX_W      = VGA_IDX_W,
  parameter int FC_W       = VGA_FC_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          posx,
  input  logic [9:0]          posy,
  input  logic                blank_n_in,
  input  logic                h_sync_in,
  input  logic                v_sync_in,
  vga_tile_renderer_if.master fb_if,
  output logic [7:0]          vga_r,
  output logic [7:0]          vga_g,
  output logic [7:0]          vga_b,
  output logic                vga_h_sync,
  output logic                vga_v_sync,
  output logic                vga_blank_n
);

  // Control word travelling alongside the RAM read: {blank_n, hsync, vsync[, offx, offy]}.
`ifdef TILE_GRID_LINES_EN
  localparam int CTRL_W = 3 + 2 * TILE_SHIFT;
  localparam logic [CTRL_W-1:0] CTRL_RST = {3'b011, {(2 * TILE_SHIFT){1'b0}}};
`else
  localparam int CTRL_W = 3;
  localparam logic [CTRL_W-1:0] CTRL_RST = 3'b011;
`endif

  logic [CTRL_W-1:0] ctrl_in;
  logic [CTRL_W-1:0] ctrl_s2;
  logic              blank_s2;
  logic              hs_s2;
  logic              vs_s2;

  logic [9:0]        fb_addr_q;
  logic [IDX_W-1:0]  idx;
  logic [23:0]       rgb_d;
  logic [23:0]       rgb_q;
  logic              hs_q;
  logic              vs_q;
  logic              blank_q;

  swap_state_t       state_q;
  logic              bank_q;
  logic              swap_ack_q;
  logic [FC_W-1:0]   frame_count_q;
  logic              vs_prev_q;
  logic              frame_edge;

`ifdef TILE_GRID_LINES_EN
  assign ctrl_in = {blank_n_in, h_sync_in, v_sync_in,
                    posx[TILE_SHIFT-1:0], posy[TILE_SHIFT-1:0]};
`else
  assign ctrl_in = {blank_n_in, h_sync_in, v_sync_in};
`endif

  // S1: tile address, issued to the synchronous frame-buffer RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_addr_q <= '0;
    end else begin
      fb_addr_q <= {bank_q, tile_index(posx, posy, TILE_SHIFT, COLS, ROWS)};
    end
  end

  // S1+S2 for controls; the RAM's own output register is the S2 data stage.
  vga_delay_line #(
    .DEPTH   (2),
    .WIDTH   (CTRL_W),
    .RST_VAL (CTRL_RST)
  ) u_ctrl_delay (
    .clk (clk),
    .rst (rst),
    .d_i (ctrl_in),
    .q_o (ctrl_s2)
  );

  assign blank_s2 = ctrl_s2[CTRL_W-1];
  assign hs_s2    = ctrl_s2[CTRL_W-2];
  assign vs_s2    = ctrl_s2[CTRL_W-3];
  assign idx      = fb_if.fb_data;

  always_comb begin
    rgb_d = '0;
    if (blank_s2) begin
      rgb_d = PALETTE[idx];
`ifdef TILE_GRID_LINES_EN
      if ((ctrl_s2[2*TILE_SHIFT-1:TILE_SHIFT] == '0) || (ctrl_s2[TILE_SHIFT-1:0] == '0)) begin
        rgb_d = GRID_COLOR;
      end
`endif
    end
  end

  // S3: output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      hs_q    <= hs_s2;
      vs_q    <= vs_s2;
      blank_q <= blank_s2;
    end
  end

  assign frame_edge = vs_prev_q & ~v_sync_in;

  // A request seen on an edge cycle while IDLE only arms PEND, so it waits for the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      bank_q        <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_count_q <= '0;
      vs_prev_q     <= 1'b0;
    end else begin
      vs_prev_q  <= v_sync_in;
      swap_ack_q <= 1'b0;
      if (frame_edge) begin
        frame_count_q <= frame_count_q + FC_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (fb_if.swap_req) begin
            state_q <= PEND;
          end
        end
        PEND: begin
          if (frame_edge) begin
            bank_q     <= ~bank_q;
            swap_ack_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fb_if.fb_addr     = fb_addr_q;
  assign fb_if.swap_ack    = swap_ack_q;
  assign fb_if.bank        = bank_q;
  assign fb_if.frame_count = frame_count_q;

  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign vga_h_sync  = hs_q;
  assign vga_v_sync  = vs_q;
  assign vga_blank_n = blank_q;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Bench for vga_tile_renderer against a queue-based reference model;
// expects the grid overlay when TILE_GRID_LINES_EN is defined.
module tb_vga_tile_renderer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] posx;
  logic [9:0] posy;
  logic       blank_n_in;
  logic       h_sync_in;
  logic       v_sync_in;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       vga_h_sync;
  logic       vga_v_sync;
  logic       vga_blank_n;

  vga_tile_renderer_if #(.IDX_W(4), .FC_W(16)) fb_if ();

  vga_tile_renderer dut (
    .clk         (clk),
    .rst         (rst),
    .posx        (posx),
    .posy        (posy),
    .blank_n_in  (blank_n_in),
    .h_sync_in   (h_sync_in),
    .v_sync_in   (v_sync_in),
    .fb_if       (fb_if),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_h_sync  (vga_h_sync),
    .vga_v_sync  (vga_v_sync),
    .vga_blank_n (vga_blank_n)
  );

  always #5 clk = ~clk;

  // Synchronous frame-buffer RAM: data one clock after the address.
  logic [3:0] ram [1024];
  always @(posedge clk) fb_if.fb_data <= ram[fb_if.fb_addr];

  logic [23:0] pal [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

  typedef struct {
    int x;
    int y;
    bit bl;
    bit hs;
    bit vs;
    bit bk;
  } vec_t;

  vec_t q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  bit   bank_m  = 1'b0;
  int   fc_m    = 0;
  bit   vs_last = 1'b0;

  function automatic int tile_of(input int x, input int y);
    int c;
    int r;
    c = x / 32;
    r = y / 32;
    if (c > 19) c = 19;
    if (r > 14) r = 14;
    return r * 20 + c;
  endfunction

  function automatic logic [23:0] exp_rgb(input vec_t v);
    logic [23:0] c;
    if (!v.bl) return 24'h0;
    c = pal[ram[{v.bk, 9'(tile_of(v.x, v.y))}]];
`ifdef TILE_GRID_LINES_EN
    if ((v.x % 32 == 0) || (v.y % 32 == 0)) c = 24'h404040;
`endif
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input int x, input int y, input bit bl, input bit hs, input bit vs,
                       input bit req, input bit ack_exp);
    vec_t v;
    vec_t o;
    posx           = 10'(x);
    posy           = 10'(y);
    blank_n_in     = bl;
    h_sync_in      = hs;
    v_sync_in      = vs;
    fb_if.swap_req = req;
    v = '{x, y, bl, hs, vs, bank_m};
    if (vs_last && !vs) fc_m = (fc_m + 1) % 65536;
    vs_last = vs;
    q.push_back(v);
    @(posedge clk);
    #1;
    check("fb_addr", 32'(fb_if.fb_addr), 32'({v.bk, 9'(tile_of(x, y))}));
    check("swap_ack", 32'(fb_if.swap_ack), 32'(ack_exp));
    if (ack_exp) bank_m = ~bank_m;
    check("bank", 32'(fb_if.bank), 32'(bank_m));
    check("frame_count", 32'(fb_if.frame_count), 32'(fc_m));
    if (q.size() == 3) begin
      o = q.pop_front();
      check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb(o)));
      check("sync_blank", 32'({vga_h_sync, vga_v_sync, vga_blank_n}), 32'({o.hs, o.vs, o.bl}));
    end
    $display("vec x=%0d y=%0d bl=%b addr=%h rgb=%h ack=%b bank=%b fc=%0d",
             x, y, bl, fb_if.fb_addr, {vga_r, vga_g, vga_b}, fb_if.swap_ack,
             fb_if.bank, fb_if.frame_count);
  endtask

  task automatic check_reset_state();
    check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    check("rst_sync_blank", 32'({vga_h_sync, vga_v_sync, vga_blank_n}), 32'b110);
    check("rst_fb_addr", 32'(fb_if.fb_addr), 32'h0);
    check("rst_swap_ack", 32'(fb_if.swap_ack), 32'h0);
    check("rst_bank", 32'(fb_if.bank), 32'h0);
    check("rst_frame_count", 32'(fb_if.frame_count), 32'h0);
  endtask

  initial begin
    rst            = 1'b1;
    posx           = '0;
    posy           = '0;
    blank_n_in     = 1'b0;
    h_sync_in      = 1'b1;
    v_sync_in      = 1'b1;
    fb_if.swap_req = 1'b0;
    for (int i = 0; i < 1024; i++) ram[i] = 4'($urandom);
    ram[0] = 4'd3;
    ram[1] = 4'd5;

    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;

    // Directed pixel mapping, clamping, blanking.
    cycle(0, 0, 1, 1, 1, 0, 0);
    cycle(634, 479, 1, 1, 1, 0, 0);
    cycle(639, 479, 1, 1, 1, 0, 0);
    cycle(1023, 1023, 1, 1, 1, 0, 0);
    cycle(40, 0, 0, 1, 1, 0, 0);
    cycle(32, 7, 1, 1, 1, 0, 0);
    cycle(33, 7, 1, 1, 1, 0, 0);

    // Sync toggle pattern (the vsync fall also counts a frame).
    cycle(64, 64, 1, 0, 1, 0, 0);
    cycle(96, 64, 1, 1, 0, 0, 0);
    cycle(128, 64, 1, 0, 1, 0, 0);
    cycle(160, 64, 1, 1, 1, 0, 0);
    cycle(192, 64, 1, 0, 0, 0, 0);
    cycle(224, 64, 1, 1, 1, 0, 0);

    // Mid-frame request, swap at the next vsync fall.
    cycle(200, 200, 1, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) cycle(232 + i, 200, 1, 1, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 1, 0, 0);
    cycle(32, 32, 1, 1, 1, 0, 0);

    // Reset while PEND with bank=1: request dropped, bank back to 0.
    cycle(64, 64, 1, 1, 1, 1, 0);
    #2 rst = 1'b1;
    #1;
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    bank_m  = 1'b0;
    fc_m    = 0;
    vs_last = 1'b0;
    cycle(64, 64, 1, 1, 1, 0, 0);
    cycle(64, 64, 1, 1, 0, 0, 0);
    cycle(64, 64, 1, 1, 1, 0, 0);

    // Request on the same cycle as the edge is deferred to the following edge.
    cycle(10, 10, 1, 1, 0, 1, 0);
    cycle(10, 10, 1, 1, 1, 0, 0);
    cycle(10, 10, 1, 1, 1, 0, 0);
    cycle(10, 10, 1, 1, 0, 0, 1);

    // Request held through the ack re-arms immediately.
    cycle(20, 20, 1, 1, 1, 1, 0);
    cycle(20, 20, 1, 1, 0, 1, 1);
    cycle(20, 20, 1, 1, 0, 1, 0);
    cycle(20, 20, 1, 1, 1, 0, 0);
    cycle(20, 20, 1, 1, 0, 0, 1);
    cycle(20, 20, 1, 1, 1, 0, 0);

    // Randomized pixels within a frame.
    for (int i = 0; i < 300; i++) begin
      cycle(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
